// File: rtl/mdu_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The master issues requests; the slave (mdu_unit) returns busy and HI/LO.
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO result registers. Requests are accepted only
// while idle; mult/div hold busy for a fixed latency and commit on the final
// edge, mthi/mtlo write their register immediately.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Latched op reduced to {is_div, is_unsigned}; only codes 0-3 ever reach RUN.
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  // Result datapath from the latched operands: sign-extended product and a
  // sign-magnitude divide (quotient toward zero, remainder follows dividend).
  always_comb begin
    a_neg = ~op_q[0] & a_q[WIDTH-1];
    b_neg = ~op_q[0] & b_q[WIDTH-1];
    a_ext = {{WIDTH{a_neg}}, a_q};
    b_ext = {{WIDTH{b_neg}}, b_q};
    prod  = a_ext * b_ext;
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    // Divisor forced to 1 on zero so the divider stays defined; nothing commits then.
    b_div = (b_q == '0) ? WIDTH'(1) : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  // Next-state and register-update decode for the IDLE/RUN controller.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = bus.op[1:0];
              a_d     = bus.a;
              b_d     = bus.b;
              cnt_d   = bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and HI/LO registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: a default 32-bit instance and a 16-bit/1/3-cycle
// instance, both checked every cycle against an arithmetic reference model,
// with directed scenarios pinned to hand-computed values and a random phase.
module tb_mdu_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mdu_unit_if #(.WIDTH(32)) bus32 ();
  mdu_unit_if #(.WIDTH(16)) bus16 ();

  mdu_unit dut32 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus32.slave)
  );

  mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus16.slave)
  );

  // Stimulus per instance (index 0 = 32-bit, 1 = 16-bit).
  logic        s_start [2] = '{1'b0, 1'b0};
  logic [2:0]  s_op    [2] = '{3'd0, 3'd0};
  logic [31:0] s_a     [2] = '{32'd0, 32'd0};
  logic [31:0] s_b     [2] = '{32'd0, 32'd0};

  assign bus32.start = s_start[0];
  assign bus32.op    = s_op[0];
  assign bus32.a     = s_a[0];
  assign bus32.b     = s_b[0];
  assign bus16.start = s_start[1];
  assign bus16.op    = s_op[1];
  assign bus16.a     = s_a[1][15:0];
  assign bus16.b     = s_b[1][15:0];

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic int mult_lat(input int d);
    return (d == 0) ? 5 : 1;
  endfunction

  function automatic int div_lat(input int d);
    return (d == 0) ? 10 : 3;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus32.busy : bus16.busy;
  endfunction

  // Reference arithmetic on w-bit operands using 64-bit integers.
  function automatic void compute(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output bit wr, output logic [31:0] h, output logic [31:0] l);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned ua = {32'd0, a} & mask;
    longint unsigned ub = {32'd0, b} & mask;
    longint sa = a[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    longint sb = b[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    longint unsigned p = 64'd0;
    longint q, r;
    wr = 1'b1;
    case (op)
      3'd0: p = longint'(sa * sb);
      3'd1: p = ua * ub;
      3'd2: begin
        if (sb == 0) wr = 1'b0;
        else begin
          q = sa / sb;
          r = sa % sb;
          p = ((longint'(r) & mask) << w) | (longint'(q) & mask);
        end
      end
      default: begin
        if (ub == 0) wr = 1'b0;
        else p = (((ua % ub) & mask) << w) | ((ua / ub) & mask);
      end
    endcase
    h = 32'((p >> w) & mask);
    l = 32'(p & mask);
  endfunction

  // Reference model: remaining busy cycles plus the result waiting to land.
  int          m_left [2] = '{0, 0};
  logic [31:0] m_hi   [2] = '{32'd0, 32'd0};
  logic [31:0] m_lo   [2] = '{32'd0, 32'd0};
  bit          p_wr   [2] = '{1'b0, 1'b0};
  logic [31:0] p_hi   [2] = '{32'd0, 32'd0};
  logic [31:0] p_lo   [2] = '{32'd0, 32'd0};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_left[d] = 0;
        m_hi[d]   = 32'd0;
        m_lo[d]   = 32'd0;
      end else if (m_left[d] > 0) begin
        m_left[d]--;
        if (m_left[d] == 0 && p_wr[d]) begin
          m_hi[d] = p_hi[d];
          m_lo[d] = p_lo[d];
        end
      end else if (s_start[d]) begin
        if (s_op[d] <= 3'd3) begin
          compute(width_of(d), s_op[d], s_a[d], s_b[d], p_wr[d], p_hi[d], p_lo[d]);
          m_left[d] = (s_op[d] <= 3'd1) ? mult_lat(d) : div_lat(d);
        end else if (s_op[d] == 3'd4) begin
          m_hi[d] = s_a[d] & mask_of(d);
        end else if (s_op[d] == 3'd5) begin
          m_lo[d] = s_a[d] & mask_of(d);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("busy32", {31'd0, bus32.busy}, {31'd0, m_left[0] > 0});
    check("hi32",   bus32.hi, m_hi[0]);
    check("lo32",   bus32.lo, m_lo[0]);
    check("busy16", {31'd0, bus16.busy}, {31'd0, m_left[1] > 0});
    check("hi16",   {16'd0, bus16.hi}, m_hi[1]);
    check("lo16",   {16'd0, bus16.lo}, m_lo[1]);
  end

  task automatic drive(input int d, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    s_start[d] = st;
    s_op[d]    = op;
    s_a[d]     = a;
    s_b[d]     = b;
  endtask

  // Issue one request, scramble the operands afterwards, count busy cycles.
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    @(negedge clk);
    drive(d, 1'b1, op, a, b);
    @(negedge clk);
    drive(d, 1'b0, 3'($urandom_range(7)), $urandom, $urandom);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_of(d)) break;
      n++;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, busy_of(d)}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand(input int d);
    logic [31:0] v;
    case ($urandom_range(7))
      0:       v = 32'd0;
      1:       v = 32'd1 << (width_of(d) - 1);
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(9));
      default: v = $urandom;
    endcase
    return v & mask_of(d);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus32.busy}, 32'd0);
    check("rst_hi", bus32.hi, 32'd0);
    check("rst_lo", bus32.lo, 32'd0);
    rst = 1'b0;

    run_op(0, 3'd0, 32'hFFFF_FFFD, 32'd7, n);
    check("mult_busy", 32'(n), 32'd5);
    check("mult_hi", bus32.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus32.lo, 32'hFFFF_FFEB);

    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_hi", bus32.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus32.lo, 32'h0000_0001);

    run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("div_busy", 32'(n), 32'd10);
    check("div_lo", bus32.lo, 32'hFFFF_FFFD);
    check("div_hi", bus32.hi, 32'hFFFF_FFFF);

    run_op(0, 3'd3, 32'd7, 32'd2, n);
    check("divu_lo", bus32.lo, 32'd3);
    check("divu_hi", bus32.hi, 32'd1);

    run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", bus32.lo, 32'h8000_0000);
    check("divovf_hi", bus32.hi, 32'd0);

    run_op(0, 3'd4, 32'h1234, 32'd0, n);
    check("mthi_busy", 32'(n), 32'd0);
    check("mthi_hi", bus32.hi, 32'h1234);
    run_op(0, 3'd5, 32'h5678, 32'd0, n);
    check("mtlo_lo", bus32.lo, 32'h5678);
    run_op(0, 3'd2, 32'd5, 32'd0, n);
    check("div0_busy", 32'(n), 32'd10);
    check("div0_hi", bus32.hi, 32'h1234);
    check("div0_lo", bus32.lo, 32'h5678);

    // Requests arriving during cycles 2 and 3 of a multiply must be dropped.
    @(negedge clk);
    drive(0, 1'b1, 3'd0, 32'd3, 32'd4);
    @(negedge clk);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      if (bus32.busy) n++;
      drive(0, (i == 2) || (i == 3), (i == 2) ? 3'd5 : 3'd2,
            (i == 2) ? 32'hAAAA : 32'd9, 32'd3);
      @(negedge clk);
    end
    check("ign_busy", 32'(n), 32'd5);
    check("ign_hi", bus32.hi, 32'd0);
    check("ign_lo", bus32.lo, 32'd12);

    // Asynchronous reset in the middle of busy cycle 4 of a divide.
    @(negedge clk);
    drive(0, 1'b1, 3'd2, 32'd100, 32'd7);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, bus32.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus32.busy}, 32'd0);
    check("arst_hi", bus32.hi, 32'd0);
    check("arst_lo", bus32.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 3'd3, 32'd100, 32'd7, n);
    check("post_rst_lo", bus32.lo, 32'd14);
    check("post_rst_hi", bus32.hi, 32'd2);

    // Narrow instance with short latencies.
    run_op(1, 3'd0, 32'h8000, 32'd2, n);
    check("p16_mult_busy", 32'(n), 32'd1);
    check("p16_mult_hi", {16'd0, bus16.hi}, 32'hFFFF);
    check("p16_mult_lo", {16'd0, bus16.lo}, 32'h0000);
    run_op(1, 3'd3, 32'd9, 32'd4, n);
    check("p16_divu_busy", 32'(n), 32'd3);
    check("p16_divu_lo", {16'd0, bus16.lo}, 32'd2);
    check("p16_divu_hi", {16'd0, bus16.hi}, 32'd1);

    // Random requests on both instances, including starts while busy.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        drive(d, $urandom_range(2) == 0, 3'($urandom_range(7)), rnd_operand(d), rnd_operand(d));
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (20) @(negedge clk);
    check("final_idle32", {31'd0, bus32.busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core that succeeds the single-cycle datapath. It sits beside the ALU in the execute stage. It accepts mult/multu/div/divu/mthi/mtlo requests and models the multi-cycle latency with a down-counter. It raises `busy` so the hazard unit can stall dependent HI/LO instructions. Operand width and both latencies are parameters.

## Interface
- `WIDTH`, 32: operand width and HI/LO register width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥1.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: request strobe, sampled on the rising edge of `clk`.
- `op`  in  3: request code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- `a`  in  WIDTH: rs operand.
- `b`  in  WIDTH: rt operand.
- `busy`  out  1: a multiply or divide is in flight.
- `hi`  out  WIDTH: HI register, driven directly from the flop (read path for mfhi).
- `lo`  out  WIDTH: LO register, driven directly from the flop (read path for mflo).

## Operation
- **States.**
  - IDLE: `busy`=0.
  - RUN: `busy`=1. Holds latched operands, latched op, and counter `cnt` of width $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- **IDLE with `start`=1.**
  - op 0–3: latch `a`, `b`, `op`. Load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - op 4: `hi` ← `a`. Stay in IDLE.
  - op 5: `lo` ← `a`. Stay in IDLE.
  - op 6–7: no effect.
- **RUN, each cycle.** `cnt` decrements by 1.
- **RUN, on the edge where `cnt`==1.** Commit the result, return to IDLE.
  - MULT: {hi,lo} ← signed(a)×signed(b), full 2·WIDTH product.
  - MULTU: {hi,lo} ← unsigned product.
  - DIV: lo ← quotient truncated toward zero; hi ← remainder, which carries the sign of the dividend.
  - DIVU: lo ← unsigned quotient; hi ← unsigned remainder.
  - DIV, most-negative ÷ −1: lo ← 0x8000…0, hi ← 0.
  - Divide by zero (b==0, DIV or DIVU): full DIV_CYCLES busy, then hi/lo left unchanged.
- **Requests during RUN.** Any `start` while `busy`=1 is ignored, including MTHI/MTLO. The pipeline stall prevents this; the unit does not queue.
- **Back-to-back.** A `start` on the same edge that commits (`cnt`==1) is also ignored. A new request is accepted only when `busy`=0 at the sampling edge.
- **Operand latching.** Changes to `a`, `b`, `op` after the accepting edge have no effect on the in-flight operation.
- **Reset.** Asynchronous assertion at any time, including mid-RUN:
  - `busy`=0, `hi`=0, `lo`=0, `cnt`=0, state IDLE.
  - The in-flight operation is discarded.

## Timing
- `start` accepted at edge E0 with op 0–3:
  - `busy`=1 from after E0 through the cycle before E0+N, where N=MULT_CYCLES or DIV_CYCLES.
  - At edge E0+N: `busy` falls and `hi`/`lo` take the result simultaneously.
  - Net effect: exactly N cycles with `busy` high.
- MTHI/MTLO: 1-cycle latency. Value is visible after the accepting edge; `busy` never asserts.
- `hi`/`lo` change only at commit, MTHI/MTLO, or reset. They are stable throughout RUN and keep their previous values.
- Outputs are registered with no combinational path from inputs. `busy` is decoded from the state flop only.

## Test plan
- **Signed multiply.** Reset, then MULT a=0xFFFFFFFD, b=7. Require `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULTU a=b=0xFFFFFFFF. Require hi=0xFFFFFFFE, lo=0x00000001.
- **Divide results.**
  - DIV a=0xFFFFFFF9 (−7), b=2: `busy` 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2: lo=3, hi=1.
  - DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- **Divide by zero.** MTHI 0x1234, MTLO 0x5678, then DIV a=5, b=0. Require `busy` 10 cycles and hi=0x1234, lo=0x5678 afterwards.
- **Requests during busy.** Start MULT 3×4. At cycle 2 of busy, pulse MTLO a=0xAAAA; at cycle 3, pulse DIV. Require both ignored: `busy` falls after exactly 5 cycles, hi=0, lo=12.
- **Reset mid-operation.** Start DIV 100/7 and assert `reset` asynchronously mid-cycle during busy cycle 4. Require `busy`, hi, lo all 0 immediately, without waiting for a clock edge. After release, DIVU 100/7 yields lo=14, hi=2.
- **Parameter override.** Instantiate with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3. MULT 0x8000×2 must give hi=0xFFFF, lo=0x0000 with `busy` high for 1 cycle. DIVU 9/4 must give lo=2, hi=1 after 3 busy cycles.
